mux_sel_rr_arbiter_8: RTL and testbench
=======================================

# mux_sel_rr_arbiter_8

Round-robin arbiter that shares one 8:1, 1-bit multiplexer (the CPU's shared single-bit bus slice) between eight requesters. It owns the mux's 3-bit select and issues a one-hot grant per requester, holding ownership until the owner releases or a hold limit forces rotation. Sits between the requesting units and `mux_8x1_1bit`; `select` wires directly to that mux.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while another requester waits; 0 = unlimited, release only.
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  8  request per requester; bit i = requester i, routed to mux input `in<i>`.
- `grant`  output  8  one-hot grant, all-zero when idle; registered.
- `select`  output  3  mux select, equals the index of the granted requester; registered.
- `busy`  output  1  high while any grant is asserted; registered.

## Operation
- The interface is fixed: one clock; reset is synchronous and active-high.
- State: `IDLE` (no owner), `OWNED` (one owner). Registers: `state`, `owner[2:0]`, `ptr[2:0]` (last granted index), `hold_cnt`.
- Priority pick: search `req` starting at `(ptr+1) mod 8`, wrapping; the first set bit wins. `ptr` updates to the winner on every new grant.
- `IDLE`: any `req` bit set → `OWNED` with the picked winner; otherwise stay.
- `OWNED`, owner's `req` high:
  - Another req pending and `MAX_HOLD != 0` and `hold_cnt == MAX_HOLD-1` → forced rotation to the next picked requester, with the owner excluded from the search. `hold_cnt` is cleared.
  - Otherwise keep the owner. `hold_cnt` increments and saturates at MAX_HOLD-1. If no other req is pending, `hold_cnt` is cleared instead.
- `OWNED`, owner's `req` low (release): if any other req is set, grant the picked one on the same edge (no bubble). Otherwise → `IDLE`, `grant`=0.
- `select` holds its last value in `IDLE` so the mux output stays stable. `busy` = (state == `OWNED`).
- Reset values: `grant`=0, `select`=0, `busy`=0, `state`=`IDLE`, `ptr`=7 (requester 0 wins first), `hold_cnt`=0. Reset mid-ownership drops the grant on the next edge, whatever `req` is.

## Timing
- Request-to-grant latency: 1 cycle. `req` is sampled at edge N and `grant`/`select` are valid after edge N.
- Release-to-next-grant: 0 bubble cycles. Release is sampled at edge M; the old grant falls and the new grant rises after edge M.
- The mux data path is combinational. The consumer samples the mux output in the same cycle `grant` is high.
- Simultaneous requests are resolved in one cycle by the rotating pointer. No requester waits more than 7 grant tenures. Each tenure is at most MAX_HOLD cycles when MAX_HOLD≠0.
- Outputs never show two grant bits or an X select after reset.

## Structure
- Package `mux_arb_pkg`:
  - constants `NUM_REQ=8`, `SEL_W=3`;
  - `arb_state_t` enum {`IDLE`, `OWNED`};
  - function `onehot8(idx)`.
- Sub-module `rr_pick_8`: purely combinational.
  - Inputs: `req[7:0]`, `start[2:0]`, `exclude_en`, `exclude_idx[2:0]`.
  - Outputs: `found`, `idx[2:0]`.
  - Instantiated once in the arbiter.
- Top: state/owner/ptr/hold_cnt registers plus next-state logic, about 150–250 lines total.

## Test plan
- Reset, then `req`=8'h00 for 3 cycles → `grant`=0, `select`=0, `busy`=0 throughout; raise `req`=8'h01 → `grant`=8'h01, `select`=0 one cycle later.
- `req`=8'hFF held, MAX_HOLD=4 → owners rotate 0,1,…,7,0, 4 cycles each; `select` steps 0..7 and wraps to 0.
- Owner 2 holds while `req`=8'h24. Drop bit 2 → next edge `grant`=8'h20, `select`=5, no idle cycle.
- Single requester 6, MAX_HOLD=4, held 20 cycles alone → grant never drops and `hold_cnt` never forces a rotation. Add `req[3]` → switch to 3 after at most 4 more cycles.
- `reset` pulsed while requester 4 is granted and `req`=8'hFF → next edge all outputs reset. The following grant goes to requester 0, since `ptr` is back at 7.
- MAX_HOLD=0 with `req`=8'h81 and owner 0 holding for 50 cycles → no rotation. Release → `grant`=8'h80 on the next edge.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way mux-select arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  // One-hot vector with only bit idx set.
  function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Combinational rotating-priority picker: first set request at or after
// 'start' (wrapping), with one optional index masked out of the search.
module rr_pick_8
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   start,
  input  logic               exclude_en,
  input  logic [SEL_W-1:0]   exclude_idx,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] rotated;
  logic [SEL_W-1:0]   offset;

  assign masked = req & ~(exclude_en ? onehot8(exclude_idx) : '0);

  // Rotate so that bit 0 of 'rotated' is the requester at 'start'.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [SEL_W-1:0] src;
    assign src         = start + SEL_W'(gi);
    assign rotated[gi] = masked[src];
  end

  // Lowest set bit of the rotated vector is the nearest requester after start.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = SEL_W'(i);
      end
    end
  end

  assign idx = start + offset;

endmodule

// File: rtl/mux_sel_rr_arbiter_8.sv
// Round-robin owner of the shared 8:1 single-bit mux. Grants are held until
// the owner releases, or until MAX_HOLD cycles have elapsed while someone
// else waits. All outputs are registered; select freezes while idle so the
// mux output does not glitch.
module mux_sel_rr_arbiter_8
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   select,
  output logic               busy
);

  // Counter only needs to reach MAX_HOLD-1; MAX_HOLD of 0 leaves it idle.
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIMIT =
    (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
  localparam bit HOLD_EN = (MAX_HOLD != 0);

  arb_state_t         state_reg,  state_next;
  logic [SEL_W-1:0]   owner_reg,  owner_next;
  logic [SEL_W-1:0]   ptr_reg,    ptr_next;
  logic [HOLD_W-1:0]  hold_reg,   hold_next;
  logic [NUM_REQ-1:0] grant_reg,  grant_next;
  logic [SEL_W-1:0]   select_reg, select_next;
  logic               busy_reg,   busy_next;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               take_new;

  // While owned the owner is masked out, so pick_found means "someone else
  // is waiting" in both the forced-rotation and release cases.
  rr_pick_8 u_pick (
    .req         (req),
    .start       (ptr_reg + SEL_W'(1)),
    .exclude_en  (state_reg == OWNED),
    .exclude_idx (owner_reg),
    .found       (pick_found),
    .idx         (pick_idx)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    ptr_next    = ptr_reg;
    hold_next   = hold_reg;
    grant_next  = grant_reg;
    select_next = select_reg;
    take_new    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (pick_found) begin
          take_new = 1'b1;
        end
      end
      OWNED: begin
        if (req[owner_reg]) begin
          if (pick_found && HOLD_EN && (hold_reg == HOLD_LIMIT)) begin
            take_new = 1'b1;
          end else if (!pick_found) begin
            // Uncontended ownership never counts toward the hold limit.
            hold_next = '0;
          end else if (HOLD_EN && (hold_reg != HOLD_LIMIT)) begin
            hold_next = hold_reg + 1'b1;
          end
        end else if (pick_found) begin
          // Hand over on the same edge as the release: no bubble cycle.
          take_new = 1'b1;
        end else begin
          state_next = IDLE;
          grant_next = '0;
          hold_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase

    if (take_new) begin
      state_next  = OWNED;
      owner_next  = pick_idx;
      ptr_next    = pick_idx;
      hold_next   = '0;
      grant_next  = onehot8(pick_idx);
      select_next = pick_idx;
    end

    busy_next = (state_next == OWNED);
  end

  // State and registered outputs; ptr resets to 7 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      owner_reg  <= '0;
      ptr_reg    <= SEL_W'(NUM_REQ - 1);
      hold_reg   <= '0;
      grant_reg  <= '0;
      select_reg <= '0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      ptr_reg    <= ptr_next;
      hold_reg   <= hold_next;
      grant_reg  <= grant_next;
      select_reg <= select_next;
      busy_reg   <= busy_next;
    end
  end

  assign grant  = grant_reg;
  assign select = select_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_mux_sel_rr_arbiter_8.sv
// Bench for mux_sel_rr_arbiter_8: two instances (MAX_HOLD=4 and MAX_HOLD=0)
// share the stimulus; a reference model pushes expected outputs into a queue
// per instance, popped and compared after each clock edge.
module tb_mux_sel_rr_arbiter_8;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] s;
    logic       b;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'h00;

  logic [7:0] grant4, grant0;
  logic [2:0] select4, select0;
  logic       busy4, busy0;

  int errors = 0;
  int checks = 0;

  exp_t q4[$];
  exp_t q0[$];

  // Reference model state, index 0 = MAX_HOLD 4, index 1 = MAX_HOLD 0.
  bit m_busy[2];
  int m_owner[2];
  int m_ptr[2];
  int m_hold[2];
  int m_sel[2];

  mux_sel_rr_arbiter_8 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .reset(reset), .req(req),
    .grant(grant4), .select(select4), .busy(busy4)
  );

  mux_sel_rr_arbiter_8 #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .reset(reset), .req(req),
    .grant(grant0), .select(select0), .busy(busy0)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // One edge of the reference arbiter.
  task automatic model_step(input int d, input int mh, input logic [7:0] r,
                            input logic rst, output exp_t e);
    logic [7:0] others;
    bit found;
    int win;
    bit take;
    take = 0;
    if (rst) begin
      m_busy[d] = 0; m_owner[d] = 0; m_ptr[d] = 7; m_hold[d] = 0; m_sel[d] = 0;
    end else begin
      others = r;
      if (m_busy[d]) others[m_owner[d]] = 1'b0;
      found = 0;
      win = 0;
      for (int k = 1; k <= 8; k++) begin
        int j;
        j = (m_ptr[d] + k) % 8;
        if (!found && others[j]) begin
          found = 1;
          win = j;
        end
      end
      if (!m_busy[d]) begin
        take = found;
      end else if (r[m_owner[d]]) begin
        if (found && mh != 0 && m_hold[d] == mh - 1) take = 1;
        else if (!found) m_hold[d] = 0;
        else if (mh != 0 && m_hold[d] < mh - 1) m_hold[d] = m_hold[d] + 1;
      end else if (found) begin
        take = 1;
      end else begin
        m_busy[d] = 0;
        m_hold[d] = 0;
      end
      if (take) begin
        m_busy[d] = 1; m_owner[d] = win; m_ptr[d] = win; m_hold[d] = 0; m_sel[d] = win;
      end
    end
    e.g = m_busy[d] ? (8'h01 << m_owner[d]) : 8'h00;
    e.s = 3'(m_sel[d]);
    e.b = m_busy[d];
  endtask

  // Drive one cycle, push model expectations, then pop and compare.
  task automatic cycle(input logic [7:0] r, input logic rst);
    exp_t e4, e0, x4, x0;
    req = r;
    reset = rst;
    model_step(0, 4, r, rst, e4);
    model_step(1, 0, r, rst, e0);
    q4.push_back(e4);
    q0.push_back(e0);
    @(posedge clk);
    #1;
    x4 = q4.pop_front();
    x0 = q0.pop_front();
    checks++;
    if ({grant4, select4, busy4} !== x4) begin
      errors++;
      $display("FAIL model_mh4 req=%h rst=%b: got g=%h s=%0d b=%b, want g=%h s=%0d b=%b",
               r, rst, grant4, select4, busy4, x4.g, x4.s, x4.b);
    end
    checks++;
    if ({grant0, select0, busy0} !== x0) begin
      errors++;
      $display("FAIL model_mh0 req=%h rst=%b: got g=%h s=%0d b=%b, want g=%h s=%0d b=%b",
               r, rst, grant0, select0, busy0, x0.g, x0.s, x0.b);
    end
  endtask

  task automatic test_reset();
    cycle(8'h00, 1'b1);
    cycle(8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(8'h00, 1'b0);
      checks++;
      if ({grant4, select4, busy4} !== 12'h000) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: got g=%h s=%0d b=%b, want 00/0/0",
                 i, grant4, select4, busy4);
      end
    end
    cycle(8'h01, 1'b0);
    checks++;
    if (grant4 !== 8'h01 || select4 !== 3'd0 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: got g=%h s=%0d b=%b, want 01/0/1", grant4, select4, busy4);
    end
    $display("test_reset done");
  endtask

  task automatic test_rotation();
    logic [7:0] want_g;
    cycle(8'h00, 1'b1);
    for (int c = 0; c < 36; c++) begin
      cycle(8'hFF, 1'b0);
      want_g = 8'h01 << ((c / 4) % 8);
      checks++;
      if (grant4 !== want_g || select4 !== 3'((c / 4) % 8)) begin
        errors++;
        $display("FAIL rotation cyc=%0d: got g=%h s=%0d, want g=%h s=%0d",
                 c, grant4, select4, want_g, (c / 4) % 8);
      end
    end
    checks++;
    if (grant0 !== 8'h01) begin
      errors++;
      $display("FAIL unlimited_no_rotate: got g=%h, want 01", grant0);
    end
    $display("test_rotation done");
  endtask

  task automatic test_release();
    cycle(8'h00, 1'b1);
    cycle(8'h04, 1'b0);
    cycle(8'h24, 1'b0);
    cycle(8'h24, 1'b0);
    checks++;
    if (grant4 !== 8'h04) begin
      errors++;
      $display("FAIL owner2_hold: got g=%h, want 04", grant4);
    end
    cycle(8'h20, 1'b0);
    checks++;
    if (grant4 !== 8'h20 || select4 !== 3'd5 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL release_handover: got g=%h s=%0d b=%b, want 20/5/1", grant4, select4, busy4);
    end
    cycle(8'h00, 1'b0);
    checks++;
    if (grant4 !== 8'h00 || select4 !== 3'd5 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL idle_select_hold: got g=%h s=%0d b=%b, want 00/5/0", grant4, select4, busy4);
    end
    $display("test_release done");
  endtask

  task automatic test_single_hold();
    int switched_at;
    cycle(8'h00, 1'b1);
    for (int c = 0; c < 21; c++) begin
      cycle(8'h40, 1'b0);
      checks++;
      if (grant4 !== 8'h40) begin
        errors++;
        $display("FAIL single_hold cyc=%0d: got g=%h, want 40", c, grant4);
      end
    end
    switched_at = -1;
    for (int c = 1; c <= 6; c++) begin
      cycle(8'h48, 1'b0);
      if (switched_at < 0 && grant4 === 8'h08) switched_at = c;
    end
    checks++;
    if (switched_at != 4) begin
      errors++;
      $display("FAIL contend_switch: got switch at cycle %0d, want 4", switched_at);
    end
    $display("test_single_hold done");
  endtask

  task automatic test_reset_mid();
    cycle(8'h00, 1'b1);
    cycle(8'h10, 1'b0);
    cycle(8'hFF, 1'b1);
    checks++;
    if ({grant4, select4, busy4} !== 12'h000 || {grant0, select0, busy0} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid: got g4=%h s4=%0d b4=%b g0=%h, want all zero",
               grant4, select4, busy4, grant0);
    end
    cycle(8'hFF, 1'b0);
    checks++;
    if (grant4 !== 8'h01 || grant0 !== 8'h01) begin
      errors++;
      $display("FAIL reset_ptr: got g4=%h g0=%h, want 01", grant4, grant0);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_unlimited();
    cycle(8'h00, 1'b1);
    cycle(8'h01, 1'b0);
    for (int c = 0; c < 50; c++) begin
      cycle(8'h81, 1'b0);
      checks++;
      if (grant0 !== 8'h01) begin
        errors++;
        $display("FAIL unlimited_hold cyc=%0d: got g=%h, want 01", c, grant0);
      end
    end
    cycle(8'h80, 1'b0);
    checks++;
    if (grant0 !== 8'h80 || select0 !== 3'd7) begin
      errors++;
      $display("FAIL unlimited_release: got g=%h s=%0d, want 80/7", grant0, select0);
    end
    $display("test_unlimited done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] r;
    cycle(8'h00, 1'b1);
    for (int c = 0; c < 300; c++) begin
      r = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) r = 8'h00;
      cycle(r, ($urandom_range(0, 63) == 0));
      checks++;
      if (!$onehot0(grant4) || !$onehot0(grant0)) begin
        errors++;
        $display("FAIL onehot cyc=%0d: got g4=%h g0=%h, want at most one bit", c, grant4, grant0);
      end
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_release();
    test_single_hold();
    test_reset_mid();
    test_unlimited();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
